// File: rtl/vga_pkg.sv
// Shared constants for the VGA fill sequencer: screen size, register map,
// command word bit positions and the sequencer state encoding.
package vga_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [1:0] CMD_PLOT   = 2'd0;
  localparam logic [1:0] CMD_ORIGIN = 2'd1;
  localparam logic [1:0] CMD_EXTENT = 2'd2;
  localparam logic [1:0] CMD_CTRL   = 2'd3;

  localparam int Y_MSB       = 30;
  localparam int Y_LSB       = 24;
  localparam int X_MSB       = 23;
  localparam int X_LSB       = 16;
  localparam int COL_MSB     = 2;
  localparam int COL_LSB     = 0;
  localparam int GO_BIT      = 31;
  localparam int ABORT_BIT   = 0;
  localparam int IRQ_CLR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_rect_walker.sv
// Raster walker for rectangle fills: holds the pixel currently on the VGA
// outputs and presents the following raster position plus a last-pixel flag.
module vga_rect_walker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [8:0] nxt_x,
  output logic [7:0] nxt_y,
  output logic       last
);

  logic [8:0] cur_x;
  logic [7:0] cur_y;
  logic [8:0] x_start;
  logic [8:0] x_end;
  logic [7:0] y_end;
  logic       row_end;

  // End coordinates are computed once at load so the step path is a compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_x   <= '0;
      cur_y   <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else if (load) begin
      cur_x   <= {1'b0, x0};
      cur_y   <= {1'b0, y0};
      x_start <= {1'b0, x0};
      x_end   <= {1'b0, x0} + {1'b0, w} - 9'd1;
      y_end   <= {1'b0, y0} + {1'b0, h} - 8'd1;
    end else if (step) begin
      cur_x <= nxt_x;
      cur_y <= nxt_y;
    end
  end

  always_comb begin
    row_end = (cur_x == x_end);
    nxt_x   = row_end ? x_start : cur_x + 9'd1;
    nxt_y   = row_end ? cur_y + 8'd1 : cur_y;
  end

  assign last = row_end && (cur_y == y_end);

endmodule

// File: rtl/vga_fill_sequencer.sv
// Command sequencer feeding the VGA adapter with single plots and clipped
// rectangle fills. Optional sticky fill-complete irq: VGA_FILL_SEQ_IRQ_EN.
module vga_fill_sequencer
  import vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        irq,
  output logic        vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour
);

  localparam logic [8:0] LIM_X = 9'(SCREEN_W);
  localparam logic [7:0] LIM_Y = 8'(SCREEN_H);

  state_t     state;
  logic [7:0] x0_reg;
  logic [6:0] y0_reg;
  logic [2:0] colour_reg;

  logic [7:0] f_x;
  logic [6:0] f_y;
  logic [2:0] f_col;
  logic       accept;
  logic       is_plot;
  logic       is_origin;
  logic       is_extent;
  logic       is_ctrl;
  logic       go_fill;
  logic       go_empty;
  logic       abort;
  logic [8:0] nxt_x;
  logic [7:0] nxt_y;
  logic       last;
  logic       unused_cmd;

  assign f_x   = cmd_data[X_MSB:X_LSB];
  assign f_y   = cmd_data[Y_MSB:Y_LSB];
  assign f_col = cmd_data[COL_MSB:COL_LSB];

  // CTRL stays writable during a fill so abort and irq clear can get through.
  assign cmd_ready = (state == IDLE) || (cmd_addr == CMD_CTRL);
  assign accept    = cmd_valid && cmd_ready;
  assign is_plot   = accept && (cmd_addr == CMD_PLOT);
  assign is_origin = accept && (cmd_addr == CMD_ORIGIN);
  assign is_extent = accept && (cmd_addr == CMD_EXTENT);
  assign is_ctrl   = accept && (cmd_addr == CMD_CTRL);
  assign go_fill   = is_extent && cmd_data[GO_BIT] && (f_x != 8'd0) && (f_y != 7'd0);
  assign go_empty  = is_extent && cmd_data[GO_BIT] && !go_fill;
  assign abort     = is_ctrl && cmd_data[ABORT_BIT];
  assign unused_cmd = ^{cmd_data[15:3], cmd_data[IRQ_CLR_BIT]};

  vga_rect_walker u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go_fill),
    .step  ((state == FILL) && !last),
    .x0    (x0_reg),
    .y0    (y0_reg),
    .w     (f_x),
    .h     (f_y),
    .nxt_x (nxt_x),
    .nxt_y (nxt_y),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x0_reg     <= '0;
      y0_reg     <= '0;
      colour_reg <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      done     <= 1'b0;
      vga_plot <= 1'b0;
      case (state)
        IDLE: begin
          if (is_plot) begin
            vga_x      <= f_x;
            vga_y      <= f_y;
            vga_colour <= f_col;
            vga_plot   <= ({1'b0, f_x} < LIM_X) && ({1'b0, f_y} < LIM_Y);
          end
          if (is_origin) begin
            x0_reg     <= f_x;
            y0_reg     <= f_y;
            colour_reg <= f_col;
          end
          // The first fill pixel comes straight from the origin registers.
          if (go_fill) begin
            state      <= FILL;
            busy       <= 1'b1;
            vga_x      <= x0_reg;
            vga_y      <= y0_reg;
            vga_colour <= colour_reg;
            vga_plot   <= ({1'b0, x0_reg} < LIM_X) && ({1'b0, y0_reg} < LIM_Y);
          end else if (go_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        FILL: begin
          if (abort || last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            vga_x    <= nxt_x[7:0];
            vga_y    <= nxt_y[6:0];
            vga_plot <= (nxt_x < LIM_X) && (nxt_y < LIM_Y);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef VGA_FILL_SEQ_IRQ_EN
  logic irq_set;
  logic irq_clr;

  // An aborted fill never raises irq, even if it was on its last pixel.
  assign irq_set = go_empty || ((state == FILL) && last && !abort);
  assign irq_clr = is_ctrl && cmd_data[IRQ_CLR_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fill_sequencer.sv
// Randomised self-checking bench for vga_fill_sequencer against a
// pixel-list reference model; honours VGA_FILL_SEQ_IRQ_EN when defined.
module tb_vga_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_addr = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        irq;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

`ifdef VGA_FILL_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  vga_fill_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .done       (done),
    .irq        (irq),
    .vga_plot   (vga_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic       done;
    logic       irq;
  } out_t;

  out_t       exp_out;
  int         px_q[$];
  int         py_q[$];
  int         m_x0;
  int         m_y0;
  logic [2:0] m_col;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [31:0] mkWord(input bit go, input int y, input int x, input int c);
    logic [31:0] wd;
    wd = 32'd0;
    wd[31]    = go;
    wd[30:24] = 7'(y);
    wd[23:16] = 8'(x);
    wd[2:0]   = 3'(c);
    return wd;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Next-cycle expectation derived from the command rules and a pixel list.
  task automatic modelStep(input logic rst, input logic acc, input logic [1:0] a, input logic [31:0] d);
    out_t nxt;
    bit   set_irq;
    int   w;
    int   h;
    set_irq = 1'b0;
    if (!rst) begin
      nxt = '0;
      px_q.delete();
      py_q.delete();
      m_x0 = 0;
      m_y0 = 0;
      m_col = 3'd0;
    end else begin
      nxt = exp_out;
      nxt.plot = 1'b0;
      nxt.busy = 1'b0;
      nxt.done = 1'b0;
      if (exp_out.busy) begin
        if (acc && a == 2'd3 && d[0]) begin
          nxt.done = 1'b1;
          px_q.delete();
          py_q.delete();
        end else if (px_q.size() > 0) begin
          nxt.x = 8'(px_q[0] % 256);
          nxt.y = 7'(py_q[0] % 128);
          nxt.plot = (px_q[0] < 160) && (py_q[0] < 120);
          nxt.busy = 1'b1;
          void'(px_q.pop_front());
          void'(py_q.pop_front());
        end else begin
          nxt.done = 1'b1;
          set_irq = 1'b1;
        end
      end else if (!exp_out.done && acc) begin
        case (a)
          2'd0: begin
            nxt.x = d[23:16];
            nxt.y = d[30:24];
            nxt.colour = d[2:0];
            nxt.plot = (int'(d[23:16]) < 160) && (int'(d[30:24]) < 120);
          end
          2'd1: begin
            m_x0 = int'(d[23:16]);
            m_y0 = int'(d[30:24]);
            m_col = d[2:0];
          end
          2'd2: begin
            if (d[31]) begin
              w = int'(d[23:16]);
              h = int'(d[30:24]);
              if (w == 0 || h == 0) begin
                nxt.done = 1'b1;
                set_irq = 1'b1;
              end else begin
                for (int yy = m_y0; yy < m_y0 + h; yy++)
                  for (int xx = m_x0; xx < m_x0 + w; xx++) begin
                    px_q.push_back(xx);
                    py_q.push_back(yy);
                  end
                nxt.x = 8'(px_q[0] % 256);
                nxt.y = 7'(py_q[0] % 128);
                nxt.colour = m_col;
                nxt.plot = (px_q[0] < 160) && (py_q[0] < 120);
                nxt.busy = 1'b1;
                void'(px_q.pop_front());
                void'(py_q.pop_front());
              end
            end
          end
          default: ;
        endcase
      end
      if (IRQ_EN) begin
        if (set_irq) nxt.irq = 1'b1;
        else if (acc && a == 2'd3 && d[1]) nxt.irq = 1'b0;
      end
    end
    exp_out = nxt;
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [31:0] d,
                               input logic rst, output logic acc);
    logic exp_ready;
    checkOutput("vga_plot", 32'(vga_plot), 32'(exp_out.plot));
    checkOutput("vga_x", 32'(vga_x), 32'(exp_out.x));
    checkOutput("vga_y", 32'(vga_y), 32'(exp_out.y));
    checkOutput("vga_colour", 32'(vga_colour), 32'(exp_out.colour));
    checkOutput("busy", 32'(busy), 32'(exp_out.busy));
    checkOutput("done", 32'(done), 32'(exp_out.done));
    checkOutput("irq", 32'(irq), 32'(exp_out.irq));
    rst_n = rst;
    cmd_valid = v;
    cmd_addr = a;
    cmd_data = d;
    #1;
    exp_ready = (!exp_out.busy && !exp_out.done) || (a == 2'd3);
    if (rst) checkOutput("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    acc = v && rst && exp_ready;
    modelStep(rst, acc, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, acc);
  endtask

  task automatic sendCmd(input logic [1:0] a, input logic [31:0] d);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20000) begin
      applyStimulus(1'b1, a, d, 1'b1, acc);
      n++;
    end
    if (!acc) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    logic [1:0]  ra;
    logic [31:0] rd;
    logic        rv;
    logic        rr;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_out = '0;
    m_x0 = 0;
    m_y0 = 0;
    m_col = 3'd0;

    idleCycles(2);
    sendCmd(2'd0, 32'h0520_0003);
    sendCmd(2'd0, mkWord(1'b0, 5, 160, 3));
    sendCmd(2'd0, mkWord(1'b0, 120, 7, 5));
    idleCycles(2);

    sendCmd(2'd1, mkWord(1'b0, 20, 10, 2));
    sendCmd(2'd2, mkWord(1'b1, 2, 3, 0));
    idleCycles(9);

    sendCmd(2'd1, mkWord(1'b0, 119, 158, 6));
    sendCmd(2'd2, mkWord(1'b1, 2, 4, 0));
    idleCycles(10);

    sendCmd(2'd2, mkWord(1'b1, 5, 0, 0));
    idleCycles(3);
    sendCmd(2'd3, 32'h2);
    idleCycles(2);

    sendCmd(2'd1, mkWord(1'b0, 0, 0, 4));
    sendCmd(2'd2, mkWord(1'b1, 100, 100, 0));
    idleCycles(49);
    sendCmd(2'd3, 32'h1);
    idleCycles(3);

    sendCmd(2'd1, mkWord(1'b0, 30, 40, 1));
    sendCmd(2'd2, mkWord(1'b1, 1, 3, 0));
    idleCycles(2);
    sendCmd(2'd3, 32'h1);
    idleCycles(3);

    sendCmd(2'd2, mkWord(1'b1, 3, 5, 0));
    idleCycles(2);
    sendCmd(2'd0, mkWord(1'b0, 9, 77, 7));
    idleCycles(3);

    sendCmd(2'd2, mkWord(1'b1, 5, 20, 0));
    idleCycles(10);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, acc);
    idleCycles(3);

    for (int i = 0; i < 400; i++) begin
      ra = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 199) != 0);
      case (ra)
        2'd0:    rd = $urandom();
        2'd1:    rd = mkWord(1'b0, $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 7));
        2'd2:    rd = mkWord($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 12), 0);
        default: rd = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)};
      endcase
      applyStimulus(rv, ra, rd, rr, acc);
    end
    idleCycles(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
